// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Constants, state encoding and IPv4 checksum helper shared by
//            the UDP-to-MAC transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

  localparam logic [7:0]  eth_preamble_byte          = 8'h55;
  localparam logic [7:0]  eth_sfd_byte               = 8'hD5;

  localparam logic [15:0] eth_mac_length             = 16'd6;
  localparam logic [15:0] eth_mac_header_length      = 16'd14;
  localparam logic [15:0] eth_ipv4_header_length     = 16'd20;
  localparam logic [15:0] eth_udp_header_length      = 16'd8;

  localparam logic [15:0] eth_type_ip                = 16'h0800;
  localparam logic [7:0]  eth_ip_ver_ihl             = 8'h45;
  localparam logic [7:0]  eth_ip_proto_udp           = 8'h11;
  localparam logic [7:0]  eth_ip_ttl                 = 8'h40;
  localparam logic [15:0] eth_ip_flags_frag          = 16'h4000;

  localparam logic [15:0] eth_udp_max_payload_length = 16'd1472;
  localparam logic [15:0] eth_min_frame_length       = 16'd60;
  localparam logic [15:0] eth_ifg_length             = 16'd12;

  // Payload bytes needed to reach the minimum frame without padding.
  localparam logic [15:0] eth_min_payload_length     = eth_min_frame_length
                                                     - eth_mac_header_length
                                                     - eth_ipv4_header_length
                                                     - eth_udp_header_length;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    DRAIN    = 3'd6,
    IFG      = 3'd7
  } eth_tx_state_t;

  // One's-complement sum of the ten IPv4 header words (checksum word as 0),
  // end-around carry folded twice, then inverted.
  function automatic logic [15:0] eth_ip_checksum(
    input logic [15:0] total_len,
    input logic [15:0] ident,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip
  );
    logic [19:0] sum;
    sum = {12'd0, eth_ip_ver_ihl} << 8;
    sum = sum + {4'd0, total_len} + {4'd0, ident} + {4'd0, eth_ip_flags_frag}
        + {4'd0, eth_ip_ttl, eth_ip_proto_udp}
        + {4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]}
        + {4'd0, dst_ip[31:16]} + {4'd0, dst_ip[15:0]};
    sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
    sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
    return ~sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_to_mac_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : udp_to_mac_tx_if
// Purpose  : AXI-stream style UDP payload channel with its frame length.
//            master = payload source, slave = framer.
// Revision : 1.0 - initial release
// ============================================================================
interface udp_to_mac_tx_if;
  logic        Udp_valid;
  logic [7:0]  Udp_data;
  logic        Udp_last;
  logic        Udp_ready;
  logic [15:0] Udp_length;

  modport master (output Udp_valid, Udp_data, Udp_last, Udp_length,
                  input  Udp_ready);
  modport slave  (input  Udp_valid, Udp_data, Udp_last, Udp_length,
                  output Udp_ready);
endinterface
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
// Module   : eth_crc32
// Purpose  : Byte-wide Ethernet CRC-32 (reflected 0x04C11DB7, init all-ones).
//            Crc_o is the raw register; the caller inverts it for the FCS.
//            Only instantiated when UDP_TO_MAC_TX_FCS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module eth_crc32 (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En_i,
  input  logic        Clr_i,
  input  logic [7:0]  Data_i,
  output logic [31:0] Crc_o
);

  localparam logic [31:0] c_poly_refl = 32'hEDB88320;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] w_step;

  // Fold one byte into the running CRC, least significant bit first.
  always_comb begin
    w_step = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (w_step[0] ^ Data_i[i]) w_step = (w_step >> 1) ^ c_poly_refl;
      else                       w_step = w_step >> 1;
    end
  end

  // Clear wins over enable so a new frame always starts from all-ones.
  always_comb begin
    crc_d = crc_q;
    if (Clr_i)     crc_d = 32'hFFFF_FFFF;
    else if (En_i) crc_d = w_step;
  end

  // CRC state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) crc_q <= 32'hFFFF_FFFF;
    else        crc_q <= crc_d;
  end

  assign Crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/udp_to_mac_tx.sv
`default_nettype none
// ============================================================================
// Module   : udp_to_mac_tx
// Purpose  : Wraps a UDP payload stream in UDP/IPv4/Ethernet headers and
//            emits a byte-wide GMII-style frame with preamble, padding and
//            (optionally) FCS. Malformed or under-run input is dropped.
// Config   : define UDP_TO_MAC_TX_FCS_EN to append the CRC-32 FCS.
// Revision : 1.0 - initial release
// ============================================================================
module udp_to_mac_tx
  import eth_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic [47:0]    Src_mac,
  input  logic [47:0]    Dst_mac,
  input  logic [31:0]    Src_ip,
  input  logic [31:0]    Dst_ip,
  input  logic [15:0]    Src_port,
  input  logic [15:0]    Dst_port,
  udp_to_mac_tx_if.slave Udp,
  output logic           Mac_valid,
  output logic [7:0]     Mac_data,
  output logic           Mac_error,
  output logic           Tx_done,
  output logic           Tx_dropped
);

  localparam logic [5:0] c_pre_last = 6'd7;
  localparam logic [5:0] c_hdr_last = 6'd41;
  localparam logic [5:0] c_ifg_last = 6'(eth_ifg_length - 16'd1);
  localparam logic [15:0] c_pad_last = eth_min_payload_length - 16'd1;

  eth_tx_state_t state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [15:0]   pay_cnt_q, pay_cnt_d;
  logic [15:0]   len_q;
  logic [47:0]   dst_mac_q, src_mac_q;
  logic [31:0]   src_ip_q, dst_ip_q;
  logic [15:0]   src_port_q, dst_port_q;
  logic [15:0]   ident_q;
  logic [15:0]   csum_q;

  logic          mac_valid_q, mac_valid_d;
  logic [7:0]    mac_data_q, mac_data_d;
  logic          mac_error_q, mac_error_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_dropped_q, tx_dropped_d;

  logic          w_ready;
  logic          w_latch;
  logic [15:0]   w_beat_num;
  logic [335:0]  w_hdr;

`ifdef UDP_TO_MAC_TX_FCS_EN
  localparam logic [5:0] c_fcs_last = 6'd3;
  logic          w_crc_en;
  logic          w_crc_clr;
  logic [31:0]   w_crc;
  logic [31:0]   w_fcs;

  eth_crc32 u_crc (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .En_i   (w_crc_en),
    .Clr_i  (w_crc_clr),
    .Data_i (mac_data_d),
    .Crc_o  (w_crc)
  );

  assign w_fcs = ~w_crc;
`endif

  // Full 42-byte header in transmit order, byte 0 in the top bits.
  assign w_hdr = {dst_mac_q, src_mac_q, eth_type_ip,
                  eth_ip_ver_ihl, 8'h00, len_q + 16'd28, ident_q,
                  eth_ip_flags_frag, eth_ip_ttl, eth_ip_proto_udp, csum_q,
                  src_ip_q, dst_ip_q,
                  src_port_q, dst_port_q, len_q + 16'd8, 16'h0000};

  assign w_beat_num    = pay_cnt_q + 16'd1;
  assign Udp.Udp_ready = w_ready;

  // Next-state, stream handshake and next output byte.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pay_cnt_d    = pay_cnt_q;
    mac_valid_d  = 1'b0;
    mac_data_d   = 8'h00;
    mac_error_d  = 1'b0;
    tx_done_d    = 1'b0;
    tx_dropped_d = 1'b0;
    w_ready      = 1'b0;
    w_latch      = 1'b0;
`ifdef UDP_TO_MAC_TX_FCS_EN
    w_crc_en     = 1'b0;
    w_crc_clr    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef UDP_TO_MAC_TX_FCS_EN
        w_crc_clr = 1'b1;
`endif
        cnt_d     = 6'd0;
        pay_cnt_d = 16'd0;
        if (Udp.Udp_valid) begin
          w_latch = 1'b1;
          if (Udp.Udp_length >= 16'd1 && Udp.Udp_length <= eth_udp_max_payload_length)
            state_d = PREAMBLE;
          else
            state_d = DRAIN;
        end
      end
      PREAMBLE: begin
        mac_valid_d = 1'b1;
        mac_data_d  = (cnt_q == c_pre_last) ? eth_sfd_byte : eth_preamble_byte;
        cnt_d       = cnt_q + 6'd1;
        if (cnt_q == c_pre_last) begin
          cnt_d   = 6'd0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        mac_valid_d = 1'b1;
        mac_data_d  = w_hdr[{3'd0, c_hdr_last - cnt_q} * 9'd8 +: 8];
`ifdef UDP_TO_MAC_TX_FCS_EN
        w_crc_en    = 1'b1;
`endif
        cnt_d       = cnt_q + 6'd1;
        if (cnt_q == c_hdr_last) begin
          cnt_d   = 6'd0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        w_ready     = 1'b1;
        mac_valid_d = 1'b1;
        if (!Udp.Udp_valid) begin
          // Under-run: flag a poisoned byte and discard the rest of the frame.
          mac_error_d = 1'b1;
          state_d     = DRAIN;
        end else begin
          mac_data_d = Udp.Udp_data;
`ifdef UDP_TO_MAC_TX_FCS_EN
          w_crc_en   = 1'b1;
`endif
          pay_cnt_d  = w_beat_num;
          if (Udp.Udp_last && w_beat_num != len_q) begin
            mac_error_d  = 1'b1;
            tx_dropped_d = 1'b1;
            cnt_d        = 6'd0;
            state_d      = IFG;
          end else if (!Udp.Udp_last && w_beat_num == len_q) begin
            mac_error_d = 1'b1;
            state_d     = DRAIN;
          end else if (Udp.Udp_last) begin
            cnt_d = 6'd0;
            if (w_beat_num < eth_min_payload_length) begin
              state_d = PAD;
            end else begin
`ifdef UDP_TO_MAC_TX_FCS_EN
              state_d   = FCS;
`else
              tx_done_d = 1'b1;
              state_d   = IFG;
`endif
            end
          end
        end
      end
      PAD: begin
        mac_valid_d = 1'b1;
`ifdef UDP_TO_MAC_TX_FCS_EN
        w_crc_en    = 1'b1;
`endif
        pay_cnt_d   = pay_cnt_q + 16'd1;
        if (pay_cnt_q == c_pad_last) begin
          cnt_d = 6'd0;
`ifdef UDP_TO_MAC_TX_FCS_EN
          state_d   = FCS;
`else
          tx_done_d = 1'b1;
          state_d   = IFG;
`endif
        end
      end
`ifdef UDP_TO_MAC_TX_FCS_EN
      FCS: begin
        mac_valid_d = 1'b1;
        mac_data_d  = w_fcs[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d       = cnt_q + 6'd1;
        if (cnt_q == c_fcs_last) begin
          tx_done_d = 1'b1;
          cnt_d     = 6'd0;
          state_d   = IFG;
        end
      end
`endif
      DRAIN: begin
        w_ready = 1'b1;
        if (Udp.Udp_valid && Udp.Udp_last) begin
          tx_dropped_d = 1'b1;
          cnt_d        = 6'd0;
          state_d      = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == c_ifg_last) begin
          cnt_d   = 6'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered MAC-side outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      pay_cnt_q    <= 16'd0;
      mac_valid_q  <= 1'b0;
      mac_data_q   <= 8'h00;
      mac_error_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      mac_valid_q  <= mac_valid_d;
      mac_data_q   <= mac_data_d;
      mac_error_q  <= mac_error_d;
      tx_done_q    <= tx_done_d;
      tx_dropped_q <= tx_dropped_d;
    end
  end

  // Frame parameters are captured once, in the IDLE cycle that sees valid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      len_q      <= 16'd0;
      dst_mac_q  <= 48'd0;
      src_mac_q  <= 48'd0;
      src_ip_q   <= 32'd0;
      dst_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
      dst_port_q <= 16'd0;
    end else if (w_latch) begin
      len_q      <= Udp.Udp_length;
      dst_mac_q  <= Dst_mac;
      src_mac_q  <= Src_mac;
      src_ip_q   <= Src_ip;
      dst_ip_q   <= Dst_ip;
      src_port_q <= Src_port;
      dst_port_q <= Dst_port;
    end
  end

  // Checksum settles during the preamble, long before its header slot.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  csum_q <= 16'd0;
    else if (state_q == PREAMBLE) csum_q <= eth_ip_checksum(len_q + 16'd28, ident_q,
                                                            src_ip_q, dst_ip_q);
  end

  // IP identification advances only on successfully completed frames.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)         ident_q <= 16'd0;
    else if (tx_done_d) ident_q <= ident_q + 16'd1;
  end

  assign Mac_valid  = mac_valid_q;
  assign Mac_data   = mac_data_q;
  assign Mac_error  = mac_error_q;
  assign Tx_done    = tx_done_q;
  assign Tx_dropped = tx_dropped_q;

endmodule
`default_nettype wire
